sync_fifo: RTL

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both ends and a live occupancy count. It sits directly downstream of the comm_fpga channel-0 host-to-FPGA pipe (producer end) and upstream of on-board consumers such as LED/timer drains (consumer end). The same block also buffers counter-generated data ahead of the FPGA-to-host pipe. Occupancy is exported for host readback and for the seven-segment display.

---
 rtl/sync_fifo.sv | 72 +++++++
 1 files changed

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with valid/ready on both ends and a live occupancy count.
// Optional high-water mark register enabled by defining SYNC_FIFO_PEAK_EN.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    output logic [DEPTH_LOG2:0]   depth_out,
    input  logic [WIDTH-1:0]      inputData_in,
    input  logic                  inputValid_in,
    output logic                  inputReady_out,
    output logic [WIDTH-1:0]      outputData_out,
    output logic                  outputValid_out,
    input  logic                  outputReady_in
`ifdef SYNC_FIFO_PEAK_EN
    ,
    output logic [DEPTH_LOG2:0]   peak_out,
    input  logic                  peakClear_in
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp, rp;
    logic [DEPTH_LOG2:0]   count;
    logic                  push, pop;

    // Handshakes derive only from registered count, so no input-to-output path exists.
    assign inputReady_out  = (count != FULL);
    assign outputValid_out = (count != '0);
    assign outputData_out  = mem[rp];
    assign depth_out       = count;

    assign push = inputValid_in  & inputReady_out;
    assign pop  = outputValid_out & outputReady_in;

    // Storage is intentionally not reset.
    always_ff @(posedge clk_in) begin
        if (push) mem[wp] <= inputData_in;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_PEAK_EN
    logic [DEPTH_LOG2:0] peak;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)          peak <= '0;
        else if (peakClear_in)  peak <= count;
        else if (count > peak)  peak <= count;
    end

    assign peak_out = peak;
`endif

endmodule
